// File: rtl/edsac_timing_pkg.sv
// edsac_timing_pkg: shared digit-timing constants and the major-cycle FSM state type
package edsac_timing_pkg;
   localparam int DIGITS_PER_MINOR     = 36;
   localparam int DEFAULT_MINOR_CYCLES = 16;
   typedef enum logic {SEARCH, LOCKED} state_t;
endpackage

// File: rtl/dpulse_encoder.sv
// dpulse_encoder: combinational 36-bit one-hot to 6-bit index encoder with one-hot valid flag
module dpulse_encoder
   import edsac_timing_pkg::*;
(
   input  logic [DIGITS_PER_MINOR-1:0] pulse,
   output logic [5:0]                  idx,
   output logic                        one_hot
);
   always_comb begin
      idx = '0;
      for (int i = 0; i < DIGITS_PER_MINOR; i++)
         if (pulse[i]) idx = idx | 6'(i);
      one_hot = (pulse != '0) && ((pulse & (pulse - DIGITS_PER_MINOR'(1))) == '0);
   end
endmodule

// File: rtl/major_cycle_counter.sv
// major_cycle_counter: locks to the digit stream and counts minor cycles within a major cycle.
// Define MAJOR_CYCLE_ONEHOT_CHECK_EN to enable digit-sequence fault checking (pulse_err).
module major_cycle_counter
   import edsac_timing_pkg::*;
#(
   parameter int MINOR_CYCLES = DEFAULT_MINOR_CYCLES
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DIGITS_PER_MINOR-1:0] digit_pulse,
   output logic [5:0]                  digit_num,
   output logic [3:0]                  minor_cycle,
   output logic                        major_start,
   output logic                        minor_end,
   output logic                        locked,
   output logic                        pulse_err
);
   logic [DIGITS_PER_MINOR-1:0] prev;
   state_t state, state_d;
   logic [5:0] idx;
   logic one_hot, change, fault, last, major_d, end_d;
   logic [3:0] minor_d;

   dpulse_encoder u_enc (.pulse(digit_pulse), .idx(idx), .one_hot(one_hot));

   assign change = digit_pulse != prev;
   assign last   = minor_cycle == 4'(MINOR_CYCLES - 1);
   assign locked = state == LOCKED;

`ifdef MAJOR_CYCLE_ONEHOT_CHECK_EN
   logic prev_one_hot;
   // A change is legal only if one-hot and, when the previous value was one-hot, its cyclic successor
   assign fault = change && (!one_hot ||
                  (prev_one_hot && digit_pulse != {prev[DIGITS_PER_MINOR-2:0], prev[DIGITS_PER_MINOR-1]}));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prev_one_hot <= 1'b0;
         pulse_err    <= 1'b0;
      end else begin
         prev_one_hot <= one_hot;
         if (fault) pulse_err <= 1'b1;
      end
`else
   assign fault     = 1'b0;
   assign pulse_err = 1'b0;
`endif

   always_comb begin
      state_d = state;
      minor_d = minor_cycle;
      major_d = 1'b0;
      end_d   = 1'b0;
      if (state == SEARCH) begin
         if (change && digit_pulse[0]) begin
            state_d = LOCKED;
            minor_d = '0;
            major_d = 1'b1;
         end
      end else if (fault) begin
         state_d = SEARCH;
      end else begin
         end_d = change && digit_pulse[DIGITS_PER_MINOR-1];
         if (change && digit_pulse[0]) begin
            minor_d = last ? 4'd0 : minor_cycle + 4'd1;
            major_d = last;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= SEARCH;
         prev        <= '0;
         digit_num   <= '0;
         minor_cycle <= '0;
         major_start <= 1'b0;
         minor_end   <= 1'b0;
      end else begin
         state       <= state_d;
         prev        <= digit_pulse;
         minor_cycle <= minor_d;
         major_start <= major_d;
         minor_end   <= end_d;
         if (one_hot) digit_num <= idx;
      end
endmodule
